// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame bit levels, legal prescale values.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling edge/bit counters and 3-sample majority vote around mid-bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PrescaleW = 6,
    parameter int BitCntW   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 i_active,
    input  logic                 i_rx,
    input  logic [PrescaleW-1:0] i_prescale,
    output logic                 o_bit,
    output logic                 o_smp_vld,
    output logic                 o_bit_end,
    output logic [BitCntW-1:0]   o_bit_cnt
);

    logic [PrescaleW-1:0] r_edge;
    logic [BitCntW-1:0]   r_bit_cnt;
    logic                 r_s0, r_s1, r_s2;
    logic [PrescaleW-1:0] w_half, w_half_m1, w_half_p1, w_last;
    logic                 w_third;

    assign w_half    = i_prescale >> 1;
    assign w_half_m1 = w_half - PrescaleW'(1);
    assign w_half_p1 = w_half + PrescaleW'(1);
    assign w_last    = i_prescale - PrescaleW'(1);

    assign o_smp_vld = i_active && (r_edge == w_half_p1);
    assign o_bit_end = i_active && (r_edge == w_last);
    assign o_bit_cnt = r_bit_cnt;

    // Third sample is live rx on edge P/2+1 so the vote is usable that same cycle
    assign w_third = (r_edge == w_half_p1) ? i_rx : r_s2;
    assign o_bit   = maj3(r_s0, r_s1, w_third);

    // Edge counter 0..P-1 within a bit; parked at 0 while idle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                       r_edge <= '0;
        else if (!i_active || o_bit_end) r_edge <= '0;
        else                            r_edge <= r_edge + PrescaleW'(1);
    end

    // Bit counter: 0 = start bit, 1..size = data, then parity/stop
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)           r_bit_cnt <= '0;
        else if (!i_active) r_bit_cnt <= '0;
        else if (o_bit_end) r_bit_cnt <= r_bit_cnt + BitCntW'(1);
    end

    // Capture the three mid-bit samples
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else if (i_active) begin
            if (r_edge == w_half_m1) r_s0 <= i_rx;
            if (r_edge == w_half)    r_s1 <= i_rx;
            if (r_edge == w_half_p1) r_s2 <= i_rx;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, LSB-first deserializer, parity/stop checks.
module uart_rx
    import uart_pkg::*;
#(
    parameter int size      = 8,
    parameter int PrescaleW = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RXIn,
    input  logic [PrescaleW-1:0] Prescale,
    input  logic                 ParityEn,
    input  logic                 ParityType,
    output logic [size-1:0]      ParallelData,
    output logic                 DataValid,
    output logic                 ParityError,
    output logic                 StopError
);

    localparam int BitCntW = $clog2(size + 3);

    uart_state_e          r_state, w_next;
    logic                 r_sync1, r_sync2;
    logic [PrescaleW-1:0] r_presc;
    logic                 r_pen, r_ptype, r_par_fail;
    logic [size-1:0]      r_shift;
    logic                 w_rx, w_bit, w_smp_vld, w_bit_end;
    logic [BitCntW-1:0]   w_bit_cnt;
    logic                 w_start_det, w_shift_en, w_par_chk, w_resolve;

    assign w_rx = r_sync2;

    // Two-flop synchronizer for the asynchronous line, idle-high reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RXIn;
            r_sync2 <= r_sync1;
        end
    end

    uart_rx_sampler #(
        .PrescaleW (PrescaleW),
        .BitCntW   (BitCntW)
    ) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .i_active   (r_state != IDLE),
        .i_rx       (w_rx),
        .i_prescale (r_presc),
        .o_bit      (w_bit),
        .o_smp_vld  (w_smp_vld),
        .o_bit_end  (w_bit_end),
        .o_bit_cnt  (w_bit_cnt)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // FSM next-state logic; STOP leaves right after the vote to catch a back-to-back start
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_rx) w_next = START;
            START:   if (w_bit_end) w_next = (w_bit == START_BIT) ? DATA : IDLE;
            DATA:    if (w_bit_end && (w_bit_cnt == BitCntW'(size)))
                         w_next = r_pen ? PARITY : STOP;
            PARITY:  if (w_bit_end) w_next = STOP;
            STOP:    if (w_smp_vld) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM output decode: datapath strobes
    always_comb begin
        w_start_det = (r_state == IDLE) && !w_rx;
        w_shift_en  = (r_state == DATA) && w_smp_vld;
        w_par_chk   = (r_state == PARITY) && w_smp_vld;
        w_resolve   = (r_state == STOP) && w_smp_vld;
    end

    // Frame configuration is frozen at start detection
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_presc <= '0;
            r_pen   <= 1'b0;
            r_ptype <= PARITY_EVEN;
        end else if (w_start_det) begin
            r_presc <= Prescale;
            r_pen   <= ParityEn;
            r_ptype <= ParityType;
        end
    end

    // LSB-first deserializer and parity check
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift    <= '0;
            r_par_fail <= 1'b0;
        end else begin
            if (w_shift_en)  r_shift <= {w_bit, r_shift[size-1:1]};
            if (w_start_det) r_par_fail <= 1'b0;
            else if (w_par_chk) r_par_fail <= (w_bit != ((^r_shift) ^ r_ptype));
        end
    end

    // Frame resolution: one-cycle pulses, data only updated on a good frame
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ParallelData <= '0;
            DataValid    <= 1'b0;
            ParityError  <= 1'b0;
            StopError    <= 1'b0;
        end else begin
            DataValid   <= 1'b0;
            ParityError <= 1'b0;
            StopError   <= 1'b0;
            if (w_resolve) begin
                if (w_bit == STOP_BIT) begin
                    if (r_par_fail) ParityError <= 1'b1;
                    else begin
                        ParallelData <= r_shift;
                        DataValid    <= 1'b1;
                    end
                end else begin
                    StopError   <= 1'b1;
                    ParityError <= r_par_fail;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame latency, parity/stop errors, glitches, reset abort.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RXIn;
    logic [5:0] Prescale;
    logic       ParityEn, ParityType;
    logic [7:0] ParallelData;
    logic       DataValid, ParityError, StopError;

    uart_rx #(.size(8), .PrescaleW(6)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RXIn         (RXIn),
        .Prescale     (Prescale),
        .ParityEn     (ParityEn),
        .ParityType   (ParityType),
        .ParallelData (ParallelData),
        .DataValid    (DataValid),
        .ParityError  (ParityError),
        .StopError    (StopError)
    );

    always #5 CLK = ~CLK;

    // Line drive change -> first START cycle is 3 clocks (2 sync flops + IDLE detect)
    localparam int SYNC_LAT = 3;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, ovl_cnt = 0;
    int dv_cyc = 0, prev_dv_cyc = 0, pe_cyc = 0, se_cyc = 0;
    logic [7:0] last_dv_data = '0, prev_dv_data = '0;
    int dv0, pe0, se0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse monitor
    always @(negedge CLK) begin
        if (DataValid) begin
            dv_cnt++;
            prev_dv_data = last_dv_data;
            last_dv_data = ParallelData;
            prev_dv_cyc  = dv_cyc;
            dv_cyc       = cyc;
        end
        if (ParityError) begin pe_cnt++; pe_cyc = cyc; end
        if (StopError)   begin se_cnt++; se_cyc = cyc; end
        if (DataValid && (ParityError || StopError)) ovl_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    endtask

    // Hold one bit for p cycles; optional one-cycle inversion at mid-bit
    task automatic drive_bit(input logic b, input int p, input logic gl);
        for (int j = 0; j < p; j++) begin
            RXIn = (gl && j == p/2) ? ~b : b;
            @(negedge CLK);
        end
    endtask

    task automatic send(input logic [7:0] d, input int p, input logic pen, input logic ptype,
                        input logic par_flip, input logic stop_b, input logic [7:0] gl_mask,
                        input int idle);
        Prescale   = 6'(p);
        ParityEn   = pen;
        ParityType = ptype;
        start_cyc  = cyc;
        drive_bit(1'b0, p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, gl_mask[i]);
        if (pen) drive_bit((^d) ^ ptype ^ par_flip, p, 1'b0);
        drive_bit(stop_b, p, 1'b0);
        RXIn = 1'b1;
        repeat (idle) @(negedge CLK);
    endtask

    initial begin
        int st1;
        RST = 1'b0; RXIn = 1'b1; Prescale = 6'd8; ParityEn = 1'b0; ParityType = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_data", ParallelData, 0);
        chk("rst_dv",   DataValid, 0);
        chk("rst_pe",   ParityError, 0);
        chk("rst_se",   StopError, 0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        // Good frame, P=8, even parity
        snap();
        send(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 32);
        chk("t1_dv_cnt", dv_cnt - dv0, 1);
        chk("t1_data",   ParallelData, 8'hA5);
        chk("t1_lat",    dv_cyc - start_cyc, 86 + SYNC_LAT);
        chk("t1_pe",     pe_cnt - pe0, 0);
        chk("t1_se",     se_cnt - se0, 0);

        // Odd parity, wrong parity bit, P=16
        snap();
        send(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 64);
        chk("t2_pe_cnt", pe_cnt - pe0, 1);
        chk("t2_dv_cnt", dv_cnt - dv0, 0);
        chk("t2_data",   ParallelData, 8'hA5);
        chk("t2_lat",    pe_cyc - start_cyc, 10*16 + 8 + 2 + SYNC_LAT);
        chk("t2_se",     se_cnt - se0, 0);

        // Stop bit 0, no parity, P=8
        snap();
        send(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32);
        chk("t3_se_cnt", se_cnt - se0, 1);
        chk("t3_lat",    se_cyc - start_cyc, 78 + SYNC_LAT);
        chk("t3_dv_cnt", dv_cnt - dv0, 0);
        chk("t3_pe",     pe_cnt - pe0, 0);
        chk("t3_data",   ParallelData, 8'hA5);

        // Bad parity and bad stop together
        snap();
        send(8'h0F, 8, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32);
        chk("t4_pe_cnt", pe_cnt - pe0, 1);
        chk("t4_se_cnt", se_cnt - se0, 1);
        chk("t4_dv_cnt", dv_cnt - dv0, 0);

        // Short start glitch rejected, then a good frame
        snap();
        Prescale = 6'd8; ParityEn = 1'b0;
        RXIn = 1'b0;
        repeat (3) @(negedge CLK);
        RXIn = 1'b1;
        repeat (30) @(negedge CLK);
        chk("t5_glitch_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32);
        chk("t5_dv_cnt", dv_cnt - dv0, 1);
        chk("t5_data",   ParallelData, 8'h81);

        // Back-to-back frames at P=32 with mid-bit glitches
        snap();
        send(8'h12, 32, 1'b0, 1'b0, 1'b0, 1'b1, 8'h24, 0);
        st1 = start_cyc;
        send(8'hEF, 32, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 128);
        chk("t6_dv_cnt",  dv_cnt - dv0, 2);
        chk("t6_data0",   prev_dv_data, 8'h12);
        chk("t6_data1",   last_dv_data, 8'hEF);
        chk("t6_lat0",    prev_dv_cyc - st1, 9*32 + 16 + 2 + SYNC_LAT);
        chk("t6_spacing", dv_cyc - prev_dv_cyc, 10*32);
        chk("t6_err",     (pe_cnt - pe0) + (se_cnt - se0), 0);

        // Reset during data bit 4 of 0xFF
        snap();
        Prescale = 6'd8; ParityEn = 1'b0;
        drive_bit(1'b0, 8, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 8, 1'b0);
        RXIn = 1'b1;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("t7_rst_data", ParallelData, 0);
        chk("t7_rst_dv",   DataValid, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (40) @(negedge CLK);
        chk("t7_no_pulse", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        send(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32);
        chk("t7_dv_cnt", dv_cnt - dv0, 1);
        chk("t7_data",   ParallelData, 8'h33);

        chk("no_overlap", ovl_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
